// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FAULT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD, FAULT} fetch_state_e;
`else
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_e;
`endif

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, stall hold buffer and redirect discard.
// Define FETCH_MISALIGN_CHECK_EN to add the fetch_misaligned output and FAULT state.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  instruction_fetch_if.master imem,
  output logic [31:0]         pc0_IF,
  output logic [31:0]         pc4_IF,
  output logic [31:0]         instruction_IF,
  output logic                invalid_IF
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                fetch_misaligned
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  disc_q, disc_d;
  logic [31:0]  tgt_pc;
  logic         tgt_bad;
  logic         req;
  logic [31:0]  addr;
  logic [31:0]  instr;
  logic         invalid;
  logic         ack;

  assign ack = imem.imem_ack;

`ifdef FETCH_MISALIGN_CHECK_EN
  // pend_q tracks a request abandoned on entry to FAULT whose ack is still owed.
  logic pend_q, pend_d;
  logic misaligned;
  assign tgt_pc  = redirect_pc;
  assign tgt_bad = |redirect_pc[1:0];
`else
  assign tgt_pc  = {redirect_pc[31:2], 2'b00};
  assign tgt_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    disc_d  = disc_q;
    req     = 1'b0;
    addr    = pc_q;
    instr   = NOP_INSTR;
    invalid = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    pend_d     = pend_q;
    misaligned = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (redirect) begin
          pc_d = tgt_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (tgt_bad) begin
            state_d = FAULT;
            pend_d  = !ack;
            disc_d  = pc_q;
          end else
`endif
          if (!ack) begin
            state_d = DISCARD;
            disc_d  = pc_q;
          end
        end else if (ack) begin
          instr   = imem.imem_rdata;
          invalid = 1'b0;
          if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            pc_d = next_pc(pc_q);
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = tgt_pc;
          state_d = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (tgt_bad) begin
            state_d = FAULT;
            pend_d  = 1'b0;
          end
`endif
        end else begin
          instr   = hold_q;
          invalid = 1'b0;
          if (!stall) begin
            pc_d    = next_pc(pc_q);
            state_d = FETCH;
          end
        end
      end
      DISCARD: begin
        req  = 1'b1;
        addr = disc_q;
        if (redirect) begin
          pc_d = tgt_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (tgt_bad) begin
            state_d = FAULT;
            pend_d  = !ack;
          end else
`endif
          if (ack) state_d = FETCH;
        end else if (ack) begin
          state_d = FETCH;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: begin
        misaligned = 1'b1;
        if (ack) pend_d = 1'b0;
        if (redirect) begin
          pc_d = tgt_pc;
          if (!tgt_bad) begin
            state_d = (pend_q && !ack) ? DISCARD : FETCH;
            pend_d  = 1'b0;
          end
        end
      end
`endif
      default: state_d = FETCH;
    endcase
    // Async reset must silence the bus immediately, before state flops settle.
    if (rst) begin
      req     = 1'b0;
      invalid = 1'b1;
      instr   = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      disc_q  <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      disc_q  <= disc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign pc0_IF         = pc_q;
  assign pc4_IF         = next_pc(pc_q);
  assign instruction_IF = instr;
  assign invalid_IF     = invalid;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misaligned = misaligned;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream IF/ID hold; current instruction not consumed this edge.
- redirect  in  1  control-flow change from later stage.
- redirect_pc  in  32  new fetch target.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address.
- imem_ack  in  1  read data valid.
- imem_rdata  in  32  read data.
- pc0_IF  out  32  address of presented instruction.
- pc4_IF  out  32  pc0_IF+4.
- instruction_IF  out  32  presented instruction.
- invalid_IF  out  1  presented slot is a bubble.
- fetch_misaligned  out  1  present only under FETCH_MISALIGN_CHECK_EN.
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-004 SHALL implement states FETCH, HOLD, DISCARD (plus FAULT under REQ-019).
REQ-005 Memory protocol: imem_addr stable while imem_req high until imem_ack; ack allowed in the request cycle or any later cycle; exactly one ack per request.
REQ-006 FETCH: imem_req=1, imem_addr=pc; outputs valid combinationally in ack cycle: instruction_IF=imem_rdata, pc0_IF=pc, pc4_IF=pc+4, invalid_IF=0.
REQ-007 FETCH, ack, !stall, !redirect: pc<=pc+4, stay FETCH (one instruction per cycle at zero-wait memory).
REQ-008 FETCH, ack, stall, !redirect: capture rdata to hold buffer, go HOLD; pc unchanged.
REQ-009 FETCH, no ack: invalid_IF=1, instruction_IF=32'h0000_0013, pc unchanged.
REQ-010 HOLD: imem_req=0; present buffered instruction, invalid_IF=0; on !stall pc<=pc+4, go FETCH.
REQ-011 Redirect priority over all other events; in redirect cycle invalid_IF=1 and pc<=redirect_pc.
REQ-012 Redirect in FETCH with ack same cycle, or in HOLD: drop data, go FETCH.
REQ-013 Redirect in FETCH without ack: latch outstanding address, go DISCARD.
REQ-014 DISCARD: imem_req=1 at latched old address; invalid_IF=1; on ack drop data, go FETCH at pc; further redirect updates pc, stays DISCARD.
REQ-015 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-016 Redirect while stall high SHALL still take effect immediately.

Reset
REQ-017 While rst high: state=FETCH, pc=RESET_PC, imem_req=0, invalid_IF=1, instruction_IF=32'h0000_0013, pc0_IF=RESET_PC, pc4_IF=RESET_PC+4, fetch_misaligned=0; hold buffer cleared.
REQ-018 Reset mid-transaction SHALL abandon outstanding request; first request at RESET_PC in first cycle after rst falls.

Configuration
REQ-019 With FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 enters FAULT (imem_req=0, invalid_IF=1, fetch_misaligned=1) until an aligned redirect (-> FETCH, or DISCARD per REQ-013 if a request is outstanding) or reset.
REQ-020 Without FETCH_MISALIGN_CHECK_EN: no fetch_misaligned port, no FAULT state; redirect_pc[1:0] forced to 2'b00.

Structure
REQ-021 Shared package fetch_pkg SHALL hold the state enum and constant NOP_INSTR = 32'h0000_0013.
REQ-022 Single module; no sub-module required.

Verification
REQ-023 Reset RESET_PC=32'h100, zero-wait ack -> addresses 0x100,0x104,0x108 on consecutive cycles, invalid_IF=0, pc4_IF=pc0_IF+4.
REQ-024 Ack with stall high 3 cycles -> HOLD, imem_req=0, instruction_IF stable; after stall falls next request at 0x104.
REQ-025 Redirect to 0x200 while ack pending 2 cycles at 0x104 -> imem_addr stays 0x104 until ack, data dropped with invalid_IF=1, next request 0x200.
REQ-026 pc=32'hFFFF_FFFC, ack, no stall -> next request 0x0.
REQ-027 Macro on: redirect to 0x202 -> fetch_misaligned=1, imem_req=0; redirect to 0x300 -> request 0x300. Macro off: same stimulus -> request 0x200.
REQ-028 rst asserted mid-wait-state -> outputs at reset values immediately; first request at RESET_PC after release.
